sc_pointmover: RTL and testbench

Player-point engine for the 8x8 LED-matrix game. It holds the position of the single lit point and turns debounced start/left/right pulses and a prescaled speed tick into point motion. It checks each move against the obstacle map and reports crash or goal. Its eight row buses feed the game-layer merge in front of the MAX7219 row/column multiplexer, which is the consumer of the point register.

---
 rtl/sc_pointmover_pkg.sv | 35 +++
 rtl/sc_pointmover_if.sv | 47 ++++
 rtl/sc_speedcounter.sv | 27 ++
 rtl/sc_pointmover.sv | 131 +++++++++++++
 tb/tb_sc_pointmover.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_pointmover_pkg.sv
// Shared types and constants for the LED-matrix player-point engine.
package sc_pointmover_pkg;

    localparam int unsigned DATAWIDTH_BUS_DEF       = 8;
    localparam int unsigned PRESCALER_DATAWIDTH_DEF = 23;
    localparam int unsigned SPEED_TICKS_DEF         = 5000000;
    localparam int unsigned POS_W                   = 3;
    localparam int unsigned STATE_W                 = 2;
    localparam int unsigned OBST_W                  = DATAWIDTH_BUS_DEF * DATAWIDTH_BUS_DEF;

    localparam logic [POS_W-1:0] INIT_ROW_DEF = 3'd7;
    localparam logic [POS_W-1:0] INIT_COL_DEF = 3'd4;

    // Row/column address limits of the 8x8 field
    localparam logic [POS_W-1:0] ROW_BOTTOM = 3'd0;
    localparam logic [POS_W-1:0] COL_MAX    = 3'd7;
    localparam logic [POS_W-1:0] COL_MIN    = 3'd0;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        CRASH = 2'b10,
        GOAL  = 2'b11
    } pmState_t;

    // One-hot column pattern for row rowAddr when the point sits at (pRow, pCol)
    function automatic logic [DATAWIDTH_BUS_DEF-1:0] decodeRow(
        input logic [POS_W-1:0] pRow,
        input logic [POS_W-1:0] pCol,
        input logic [POS_W-1:0] rowAddr
    );
        return (pRow == rowAddr) ? (DATAWIDTH_BUS_DEF'(1) << pCol) : '0;
    endfunction

endpackage

// File: rtl/sc_pointmover_if.sv
// Button/obstacle inputs and point/status outputs of the point engine.
interface sc_pointmover_if;
    import sc_pointmover_pkg::*;

    logic                         SC_POINTMOVER_start_InHigh;
    logic                         SC_POINTMOVER_left_InHigh;
    logic                         SC_POINTMOVER_right_InHigh;
    logic [OBST_W-1:0]            SC_POINTMOVER_obstacles_InBUS;
    logic [DATAWIDTH_BUS_DEF-1:0] SC_POINTMOVER_data7_OutBUS;
    logic [DATAWIDTH_BUS_DEF-1:0] SC_POINTMOVER_data6_OutBUS;
    logic [DATAWIDTH_BUS_DEF-1:0] SC_POINTMOVER_data5_OutBUS;
    logic [DATAWIDTH_BUS_DEF-1:0] SC_POINTMOVER_data4_OutBUS;
    logic [DATAWIDTH_BUS_DEF-1:0] SC_POINTMOVER_data3_OutBUS;
    logic [DATAWIDTH_BUS_DEF-1:0] SC_POINTMOVER_data2_OutBUS;
    logic [DATAWIDTH_BUS_DEF-1:0] SC_POINTMOVER_data1_OutBUS;
    logic [DATAWIDTH_BUS_DEF-1:0] SC_POINTMOVER_data0_OutBUS;
    logic [POS_W-1:0]             SC_POINTMOVER_row_OutBUS;
    logic [POS_W-1:0]             SC_POINTMOVER_col_OutBUS;
    logic [STATE_W-1:0]           SC_POINTMOVER_state_OutBUS;
    logic                         SC_POINTMOVER_crash_Out;
    logic                         SC_POINTMOVER_goal_Out;

    modport master (
        output SC_POINTMOVER_start_InHigh, SC_POINTMOVER_left_InHigh,
               SC_POINTMOVER_right_InHigh, SC_POINTMOVER_obstacles_InBUS,
        input  SC_POINTMOVER_data7_OutBUS, SC_POINTMOVER_data6_OutBUS,
               SC_POINTMOVER_data5_OutBUS, SC_POINTMOVER_data4_OutBUS,
               SC_POINTMOVER_data3_OutBUS, SC_POINTMOVER_data2_OutBUS,
               SC_POINTMOVER_data1_OutBUS, SC_POINTMOVER_data0_OutBUS,
               SC_POINTMOVER_row_OutBUS, SC_POINTMOVER_col_OutBUS,
               SC_POINTMOVER_state_OutBUS, SC_POINTMOVER_crash_Out,
               SC_POINTMOVER_goal_Out
    );

    modport slave (
        input  SC_POINTMOVER_start_InHigh, SC_POINTMOVER_left_InHigh,
               SC_POINTMOVER_right_InHigh, SC_POINTMOVER_obstacles_InBUS,
        output SC_POINTMOVER_data7_OutBUS, SC_POINTMOVER_data6_OutBUS,
               SC_POINTMOVER_data5_OutBUS, SC_POINTMOVER_data4_OutBUS,
               SC_POINTMOVER_data3_OutBUS, SC_POINTMOVER_data2_OutBUS,
               SC_POINTMOVER_data1_OutBUS, SC_POINTMOVER_data0_OutBUS,
               SC_POINTMOVER_row_OutBUS, SC_POINTMOVER_col_OutBUS,
               SC_POINTMOVER_state_OutBUS, SC_POINTMOVER_crash_Out,
               SC_POINTMOVER_goal_Out
    );

endinterface

// File: rtl/sc_speedcounter.sv
// Speed prescaler: counts while enabled and pulses tick_c on the terminal count.
module sc_speedcounter #(
    parameter int unsigned       WIDTH    = 23,
    parameter logic [WIDTH-1:0]  TERMINAL = '1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    logic [WIDTH-1:0] count;

    assign tick_c = en && (count == TERMINAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick_c ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sc_pointmover.sv
// Player-point engine: button edges and speed ticks move the point, the
// obstacle map decides crash, reaching row 0 is a goal.
module sc_pointmover
    import sc_pointmover_pkg::*;
#(
    parameter int unsigned                     DATAWIDTH_BUS       = DATAWIDTH_BUS_DEF,
    parameter int unsigned                     PRESCALER_DATAWIDTH = PRESCALER_DATAWIDTH_DEF,
    parameter logic [PRESCALER_DATAWIDTH-1:0]  SPEED_TICKS         = PRESCALER_DATAWIDTH'(SPEED_TICKS_DEF),
    parameter logic [POS_W-1:0]                INIT_ROW            = INIT_ROW_DEF,
    parameter logic [POS_W-1:0]                INIT_COL            = INIT_COL_DEF
) (
    input  logic            SC_POINTMOVER_CLOCK_50,
    input  logic            SC_POINTMOVER_RESET_InLow,
    sc_pointmover_if.slave  pmBus
);

    logic clk;
    logic rst_n;
    assign clk   = SC_POINTMOVER_CLOCK_50;
    assign rst_n = SC_POINTMOVER_RESET_InLow;

    pmState_t         stateQ, stateD;
    logic [POS_W-1:0] rowQ, rowD, colQ, colD;
    logic [POS_W-1:0] latCol, tgtRow, tgtCol;
    logic             prevStart, prevLeft, prevRight;
    logic             startEdge, leftEdge, rightEdge;
    logic             tick;
    logic             crashQ, goalQ;
    logic [DATAWIDTH_BUS-1:0] dataRows [DATAWIDTH_BUS];

    assign startEdge = pmBus.SC_POINTMOVER_start_InHigh & ~prevStart;
    assign leftEdge  = pmBus.SC_POINTMOVER_left_InHigh  & ~prevLeft;
    assign rightEdge = pmBus.SC_POINTMOVER_right_InHigh & ~prevRight;

    sc_speedcounter #(
        .WIDTH    (PRESCALER_DATAWIDTH),
        .TERMINAL (PRESCALER_DATAWIDTH'(SPEED_TICKS - 1'b1))
    ) uSpeed (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (stateQ == RUN),
        .clr    (stateQ != RUN),
        .tick_c (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stateQ <= IDLE;
        else        stateQ <= stateD;
    end

    // Next state and next position; lateral step is resolved before the descent
    always_comb begin
        stateD = stateQ;
        rowD   = rowQ;
        colD   = colQ;
        latCol = colQ;
        tgtRow = rowQ;
        tgtCol = colQ;
        case (stateQ)
            IDLE: begin
                rowD = INIT_ROW;
                colD = INIT_COL;
                if (startEdge) stateD = RUN;
            end
            RUN: begin
                if (leftEdge && !rightEdge && colQ != COL_MAX)      latCol = colQ + 3'd1;
                else if (rightEdge && !leftEdge && colQ != COL_MIN) latCol = colQ - 3'd1;
                tgtCol = latCol;
                tgtRow = tick ? rowQ - 3'd1 : rowQ;
                if (tgtRow != rowQ || tgtCol != colQ) begin
                    if (pmBus.SC_POINTMOVER_obstacles_InBUS[{tgtRow, tgtCol}]) begin
                        stateD = CRASH;
                    end else begin
                        rowD = tgtRow;
                        colD = tgtCol;
                        if (tgtRow == ROW_BOTTOM) stateD = GOAL;
                    end
                end
            end
            CRASH, GOAL: begin
                if (startEdge) begin
                    stateD = IDLE;
                    rowD   = INIT_ROW;
                    colD   = INIT_COL;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rowQ      <= INIT_ROW;
            colQ      <= INIT_COL;
            prevStart <= 1'b0;
            prevLeft  <= 1'b0;
            prevRight <= 1'b0;
            crashQ    <= 1'b0;
            goalQ     <= 1'b0;
            for (int r = 0; r < DATAWIDTH_BUS; r++) begin
                dataRows[r] <= decodeRow(INIT_ROW, INIT_COL, POS_W'(r));
            end
        end else begin
            rowQ      <= rowD;
            colQ      <= colD;
            prevStart <= pmBus.SC_POINTMOVER_start_InHigh;
            prevLeft  <= pmBus.SC_POINTMOVER_left_InHigh;
            prevRight <= pmBus.SC_POINTMOVER_right_InHigh;
            crashQ    <= (stateD == CRASH);
            goalQ     <= (stateD == GOAL);
            for (int r = 0; r < DATAWIDTH_BUS; r++) begin
                dataRows[r] <= decodeRow(rowD, colD, POS_W'(r));
            end
        end
    end

    assign pmBus.SC_POINTMOVER_data7_OutBUS = dataRows[7];
    assign pmBus.SC_POINTMOVER_data6_OutBUS = dataRows[6];
    assign pmBus.SC_POINTMOVER_data5_OutBUS = dataRows[5];
    assign pmBus.SC_POINTMOVER_data4_OutBUS = dataRows[4];
    assign pmBus.SC_POINTMOVER_data3_OutBUS = dataRows[3];
    assign pmBus.SC_POINTMOVER_data2_OutBUS = dataRows[2];
    assign pmBus.SC_POINTMOVER_data1_OutBUS = dataRows[1];
    assign pmBus.SC_POINTMOVER_data0_OutBUS = dataRows[0];
    assign pmBus.SC_POINTMOVER_row_OutBUS   = rowQ;
    assign pmBus.SC_POINTMOVER_col_OutBUS   = colQ;
    assign pmBus.SC_POINTMOVER_state_OutBUS = stateQ;
    assign pmBus.SC_POINTMOVER_crash_Out    = crashQ;
    assign pmBus.SC_POINTMOVER_goal_Out     = goalQ;

endmodule

// File: tb/tb_sc_pointmover.sv
// Scoreboard bench for sc_pointmover: the driver advances a game-rule model
// each cycle and queues the expected outputs; the monitor compares them.
module tb_sc_pointmover;

    localparam int SPEED = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   rstHold = 1'b1;
    bit   done = 1'b0;

    sc_pointmover_if pmBus();

    sc_pointmover #(
        .PRESCALER_DATAWIDTH (23),
        .SPEED_TICKS         (23'd4)
    ) dut (
        .SC_POINTMOVER_CLOCK_50    (clk),
        .SC_POINTMOVER_RESET_InLow (rst_n),
        .pmBus                     (pmBus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  state;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        crash;
        logic        goal;
        logic [63:0] rows;
    } snap_t;

    snap_t expQ[$];
    int checks = 0;
    int errors = 0;

    // Game model: states 0 idle, 1 run, 2 crash, 3 goal
    int mState, mRow, mCol, runCycles;
    bit pS, pL, pR;
    logic [63:0] obst = '0;

    function automatic snap_t modelSnap();
        snap_t s;
        s.state = 2'(mState);
        s.row   = 3'(mRow);
        s.col   = 3'(mCol);
        s.crash = (mState == 2);
        s.goal  = (mState == 3);
        s.rows  = '0;
        s.rows[mRow * 8 + mCol] = 1'b1;
        return s;
    endfunction

    task automatic modelReset();
        mState = 0; mRow = 7; mCol = 4; runCycles = 0;
        pS = 0; pL = 0; pR = 0;
    endtask

    task automatic modelAdvance(input bit s, input bit l, input bit r);
        bit sE, lE, rE, tk;
        int nr, nc;
        sE = s && !pS; lE = l && !pL; rE = r && !pR;
        pS = s; pL = l; pR = r;
        case (mState)
            0: if (sE) begin mState = 1; runCycles = 0; end
            1: begin
                tk = (runCycles % SPEED) == SPEED - 1;
                runCycles++;
                nc = mCol;
                if (lE && !rE && mCol < 7)      nc = mCol + 1;
                else if (rE && !lE && mCol > 0) nc = mCol - 1;
                nr = tk ? mRow - 1 : mRow;
                if (nr != mRow || nc != mCol) begin
                    if (obst[nr * 8 + nc]) mState = 2;
                    else begin
                        mRow = nr; mCol = nc;
                        if (nr == 0) mState = 3;
                    end
                end
            end
            default: if (sE) begin mState = 0; mRow = 7; mCol = 4; end
        endcase
    endtask

    task automatic step(input bit s, input bit l, input bit r);
        @(negedge clk);
        rst_n = !rstHold;
        pmBus.SC_POINTMOVER_start_InHigh    = s;
        pmBus.SC_POINTMOVER_left_InHigh     = l;
        pmBus.SC_POINTMOVER_right_InHigh    = r;
        pmBus.SC_POINTMOVER_obstacles_InBUS = obst;
        if (!rst_n) modelReset();
        else        modelAdvance(s, l, r);
        expQ.push_back(modelSnap());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    // Reset asserted between clock edges; outputs must follow without a clock
    task automatic asyncReset();
        @(negedge clk);
        #3;
        rstHold = 1'b1;
        modelReset();
        expQ.push_back(modelSnap());
        rst_n = 1'b0;
    endtask

    // Direct comparison of all outputs against the specified reset values
    task automatic checkReset();
        #1;
        checks++;
        if (pmBus.SC_POINTMOVER_state_OutBUS !== 2'b00 ||
            pmBus.SC_POINTMOVER_row_OutBUS   !== 3'd7  ||
            pmBus.SC_POINTMOVER_col_OutBUS   !== 3'd4  ||
            pmBus.SC_POINTMOVER_crash_Out    !== 1'b0  ||
            pmBus.SC_POINTMOVER_goal_Out     !== 1'b0  ||
            {pmBus.SC_POINTMOVER_data7_OutBUS, pmBus.SC_POINTMOVER_data6_OutBUS,
             pmBus.SC_POINTMOVER_data5_OutBUS, pmBus.SC_POINTMOVER_data4_OutBUS,
             pmBus.SC_POINTMOVER_data3_OutBUS, pmBus.SC_POINTMOVER_data2_OutBUS,
             pmBus.SC_POINTMOVER_data1_OutBUS, pmBus.SC_POINTMOVER_data0_OutBUS} !== 64'h1000_0000_0000_0000) begin
            errors++;
            $display("FAIL reset values t=%0t st=%0d row=%0d col=%0d crash=%0b goal=%0b data7=%h",
                     $time, pmBus.SC_POINTMOVER_state_OutBUS, pmBus.SC_POINTMOVER_row_OutBUS,
                     pmBus.SC_POINTMOVER_col_OutBUS, pmBus.SC_POINTMOVER_crash_Out,
                     pmBus.SC_POINTMOVER_goal_Out, pmBus.SC_POINTMOVER_data7_OutBUS);
        end
    endtask

    initial begin : watchdog
        #1000000;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout t=%0t driver did not finish", $time);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin : monitor
        snap_t exp, act;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (expQ.size() != 0) begin
                exp = expQ.pop_front();
                act.state = pmBus.SC_POINTMOVER_state_OutBUS;
                act.row   = pmBus.SC_POINTMOVER_row_OutBUS;
                act.col   = pmBus.SC_POINTMOVER_col_OutBUS;
                act.crash = pmBus.SC_POINTMOVER_crash_Out;
                act.goal  = pmBus.SC_POINTMOVER_goal_Out;
                act.rows  = {pmBus.SC_POINTMOVER_data7_OutBUS, pmBus.SC_POINTMOVER_data6_OutBUS,
                             pmBus.SC_POINTMOVER_data5_OutBUS, pmBus.SC_POINTMOVER_data4_OutBUS,
                             pmBus.SC_POINTMOVER_data3_OutBUS, pmBus.SC_POINTMOVER_data2_OutBUS,
                             pmBus.SC_POINTMOVER_data1_OutBUS, pmBus.SC_POINTMOVER_data0_OutBUS};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL outputs t=%0t got st=%0d row=%0d col=%0d crash=%0b goal=%0b rows=%h required st=%0d row=%0d col=%0d crash=%0b goal=%0b rows=%h",
                             $time, act.state, act.row, act.col, act.crash, act.goal, act.rows,
                             exp.state, exp.row, exp.col, exp.crash, exp.goal, exp.rows);
                end
            end
        end
    end

    initial begin : driver
        pmBus.SC_POINTMOVER_start_InHigh    = 1'b0;
        pmBus.SC_POINTMOVER_left_InHigh     = 1'b0;
        pmBus.SC_POINTMOVER_right_InHigh    = 1'b0;
        pmBus.SC_POINTMOVER_obstacles_InBUS = '0;
        modelReset();

        // Reset values, then release with no buttons
        idle(2);
        checkReset();
        rstHold = 1'b0;
        idle(3);

        // Empty map: descend to goal, then restart
        step(1, 0, 0);
        idle(32);
        step(1, 0, 0);
        idle(2);

        // Left saturation, then simultaneous left+right
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) begin step(0, 1, 0); step(0, 0, 0); end
        step(0, 1, 1);
        idle(30);
        step(1, 0, 0);
        idle(2);

        // Obstacle straight below the start cell
        obst = '0; obst[8 * 6 + 4] = 1'b1;
        step(1, 0, 0);
        idle(6);
        step(1, 0, 0);
        idle(2);

        // Left coincident with tick: blocked at (6,5), then free with block at (6,4)
        obst = '0; obst[8 * 6 + 5] = 1'b1;
        step(1, 0, 0); idle(3); step(0, 1, 0); idle(2);
        step(1, 0, 0); idle(2);
        obst = '0; obst[8 * 6 + 4] = 1'b1;
        step(1, 0, 0); idle(3); step(0, 1, 0); idle(28);
        step(1, 0, 0); idle(2);

        // Asynchronous reset while running at row 3, then a fresh game
        obst = '0;
        step(1, 0, 0);
        idle(16);
        asyncReset();
        checkReset();
        idle(2);
        rstHold = 1'b0;
        step(1, 0, 0);
        idle(10);

        // Randomized play against random sparse obstacle maps
        for (int i = 0; i < 1500; i++) begin
            if (i % 60 == 0) obst = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if ($urandom_range(0, 299) == 0) begin
                asyncReset();
                idle(2);
                rstHold = 1'b0;
            end
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        @(posedge clk);
        #3;
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
